ram_controller: RTL and testbench

- Parametrised single-port CPU RAM with a PicoRV32-native valid/ready handshake, per-byte write strobes and configurable read latency.
- Optional hardware zero-fill runs after reset.
- Sits on the CPU data/instruction bus beside ROM and peripherals; the address decoder drives sel.
- Replaces the fixed 8 KiB, 4-lane, always-one-cycle RAM macro arrangement.

---
 rtl/ram_controller_pkg.sv | 24 ++
 rtl/ram_controller_lane.sv | 35 +++
 rtl/ram_controller.sv | 123 ++++++++++++
 tb/tb_ram_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ram_controller_pkg.sv
// Shared definitions for the CPU RAM controller: FSM state encoding and a
// constant-evaluable ceiling log2 used to size lane and word-address fields.
package ram_controller_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_PIPE  = 2'd2,
        ST_DONE  = 2'd3
    } ram_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_controller_lane.sv
// One 8-bit byte lane of the CPU RAM: single-port synchronous array with a
// write enable and a read-enabled output register that holds between reads.
module ram_controller_lane #(
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk_cpu,
    input  logic                 resetn,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           din,
    output logic [7:0]           dout
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [7:0] mem [DEPTH];

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk_cpu) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Read register only updates on a CPU read so rdata holds between reads.
    always_ff @(posedge clk_cpu or negedge resetn) begin
        if (!resetn) begin
            dout <= 8'h00;
        end else if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_controller.sv
// CPU RAM controller: valid/ready handshake, byte strobes, optional output
// pipeline register and optional zero-fill of the whole array after reset.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | zero-filling one word per cycle, busy=1, sel ignored
//   ST_IDLE  | waiting for sel; write or read launched at the sampling edge
//   ST_PIPE  | read data passing through the output register (OUT_REG=1)
//   ST_DONE  | ready=1 for one cycle, sel not sampled
module ram_controller
    import ram_controller_pkg::*;
#(
    parameter int ADDR_BITS      = 13,
    parameter int DATA_BITS      = 32,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk_cpu,
    input  logic                   resetn,
    input  logic                   sel,
    input  logic [DATA_BITS/8-1:0] wen,
    input  logic [ADDR_BITS-1:0]   address,
    input  logic [DATA_BITS-1:0]   wdata,
    output logic [DATA_BITS-1:0]   rdata,
    output logic                   ready,
    output logic                   busy
);

    localparam int LANES     = DATA_BITS / 8;
    localparam int LANE_BITS = clog2(LANES);
    localparam int WORD_BITS = ADDR_BITS - LANE_BITS;

    localparam ram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    ram_state_e           state, next_state;
    logic [WORD_BITS-1:0] clr_cnt;
    logic [WORD_BITS-1:0] lane_addr;
    logic [LANES-1:0]     lane_we;
    logic                 lane_re;
    logic [DATA_BITS-1:0] lane_din;
    logic [DATA_BITS-1:0] lane_dout;

    // State register and zero-fill word counter.
    always_ff @(posedge clk_cpu or negedge resetn) begin
        if (!resetn) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Next state and lane steering between the clear path and the CPU path.
    always_comb begin
        next_state = state;
        lane_we    = '0;
        lane_re    = 1'b0;
        lane_addr  = address[ADDR_BITS-1:LANE_BITS];
        lane_din   = wdata;
        case (state)
            ST_CLEAR: begin
                lane_we   = '1;
                lane_addr = clr_cnt;
                lane_din  = '0;
                if (clr_cnt == {WORD_BITS{1'b1}}) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (sel) begin
                    if (|wen) begin
                        lane_we    = wen;
                        next_state = ST_DONE;
                    end else begin
                        lane_re    = 1'b1;
                        next_state = (OUT_REG != 0) ? ST_PIPE : ST_DONE;
                    end
                end
            end
            ST_PIPE: next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ram_controller_lane #(
            .ADDR_BITS (WORD_BITS)
        ) u_lane (
            .clk_cpu (clk_cpu),
            .resetn  (resetn),
            .we      (lane_we[i]),
            .re      (lane_re),
            .addr    (lane_addr),
            .din     (lane_din[8*i +: 8]),
            .dout    (lane_dout[8*i +: 8])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_BITS-1:0] rdata_q;

        // Extra pipeline stage: capture lane data at the end of ST_PIPE.
        always_ff @(posedge clk_cpu or negedge resetn) begin
            if (!resetn) begin
                rdata_q <= '0;
            end else if (state == ST_PIPE) begin
                rdata_q <= lane_dout;
            end
        end

        assign rdata = rdata_q;
    end else begin : g_no_out_reg
        assign rdata = lane_dout;
    end

    assign ready = (state == ST_DONE);
    assign busy  = (state == ST_CLEAR);

endmodule

// File: tb/tb_ram_controller.sv
// Directed bench for ram_controller: dut0 uses defaults (OUT_REG=0, clear on
// reset), dut1 uses OUT_REG=1 with no clear.
module tb_ram_controller;

    logic        clk_cpu;
    logic        resetn0, sel0;
    logic [3:0]  wen0;
    logic [12:0] address0;
    logic [31:0] wdata0, rdata0;
    logic        ready0, busy0;
    logic        resetn1, sel1;
    logic [3:0]  wen1;
    logic [12:0] address1;
    logic [31:0] wdata1, rdata1;
    logic        ready1, busy1;

    int n_tests = 0;
    int n_fail  = 0;
    logic busy1_seen = 1'b0;

    ram_controller u_dut0 (
        .clk_cpu (clk_cpu), .resetn (resetn0), .sel (sel0), .wen (wen0),
        .address (address0), .wdata (wdata0), .rdata (rdata0),
        .ready (ready0), .busy (busy0)
    );

    ram_controller #(.OUT_REG(1), .CLEAR_ON_RESET(0)) u_dut1 (
        .clk_cpu (clk_cpu), .resetn (resetn1), .sel (sel1), .wen (wen1),
        .address (address1), .wdata (wdata1), .rdata (rdata1),
        .ready (ready1), .busy (busy1)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    always @(negedge clk_cpu) if (busy1 !== 1'b0) busy1_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction

    // Called at a negedge; returns read data and cycles from sampling edge to ready.
    task automatic access(input int d, input logic [3:0] w, input logic [12:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        if (d == 0) begin
            sel0 = 1'b1; wen0 = w; address0 = a; wdata0 = wd;
        end else begin
            sel1 = 1'b1; wen1 = w; address1 = a; wdata1 = wd;
        end
        lat = 0;
        do begin
            @(negedge clk_cpu);
            lat++;
        end while (!rdy(d) && lat < 100);
        rd = (d == 0) ? rdata0 : rdata1;
        if (d == 0) sel0 = 1'b0; else sel1 = 1'b0;
        @(negedge clk_cpu);
        chk("ready_width", {31'b0, rdy(d)}, 32'd0);
    endtask

    // Called at the release negedge; counts cycles with busy=1 and notes any ready.
    task automatic count_busy(output int cnt, output logic rdy_seen);
        cnt = 0;
        rdy_seen = 1'b0;
        while (busy0 && cnt < 5000) begin
            if (ready0) rdy_seen = 1'b1;
            cnt++;
            @(negedge clk_cpu);
        end
    endtask

    logic [31:0] rd;
    int          lat, cnt;
    logic        rseen;

    initial begin
        resetn0 = 1'b0; sel0 = 1'b0; wen0 = '0; address0 = '0; wdata0 = '0;
        resetn1 = 1'b0; sel1 = 1'b0; wen1 = '0; address1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk_cpu);

        chk("rst0_ready", {31'b0, ready0}, 32'd0);
        chk("rst0_rdata", rdata0, 32'h0);
        chk("rst0_busy",  {31'b0, busy0},  32'd1);
        chk("rst1_busy",  {31'b0, busy1},  32'd0);
        chk("rst1_rdata", rdata1, 32'h0);

        // Release with a read of word 0 already pending during the clear.
        sel0 = 1'b1; wen0 = 4'h0; address0 = 13'h0000;
        resetn0 = 1'b1;
        resetn1 = 1'b1;
        count_busy(cnt, rseen);
        chk("clear_len", cnt, 32'd2048);
        chk("clear_no_ready", {31'b0, rseen}, 32'd0);
        lat = 0;
        while (!ready0 && lat < 100) begin
            @(negedge clk_cpu);
            lat++;
        end
        chk("stall_lat", lat, 32'd1);
        chk("stall_rdata", rdata0, 32'h0);
        sel0 = 1'b0;
        @(negedge clk_cpu);

        access(0, 4'h0, 13'h1FFC, 32'h0, rd, lat);
        chk("clr_last_word", rd, 32'h0);

        access(0, 4'hF, 13'h0100, 32'hDEADBEEF, rd, lat);
        chk("wr_lat", lat, 32'd1);
        access(0, 4'h0, 13'h0100, 32'h0, rd, lat);
        chk("rd_lat", lat, 32'd1);
        chk("rd_data", rd, 32'hDEADBEEF);
        access(0, 4'hF, 13'h0040, 32'h11223344, rd, lat);
        chk("wr_keeps_rdata", rd, 32'hDEADBEEF);
        access(0, 4'b0101, 13'h0040, 32'hAABBCCDD, rd, lat);
        access(0, 4'h0, 13'h0040, 32'h0, rd, lat);
        chk("byte_strobe", rd, 32'h11BB33DD);

        access(0, 4'hF, 13'h0004, 32'h5A5A5A5A, rd, lat);
        access(0, 4'h0, 13'h0004, 32'h0, rd, lat);
        chk("alias_base", rd, 32'h5A5A5A5A);
        access(0, 4'h0, 13'h0006, 32'h0, rd, lat);
        chk("alias_low", rd, 32'h5A5A5A5A);
        address0 = 13'h1FFF;
        // 0x2004 truncated to 13 bits is 0x0004.
        begin
            logic [13:0] wide_addr;
            wide_addr = 14'h2004;
            access(0, 4'h0, wide_addr[12:0], 32'h0, rd, lat);
        end
        chk("alias_wrap", rd, 32'h5A5A5A5A);

        // Reset pulse at clear cycle 1000 restarts the full clear.
        resetn0 = 1'b0;
        @(negedge clk_cpu);
        resetn0 = 1'b1;
        repeat (1000) @(negedge clk_cpu);
        chk("mid_busy", {31'b0, busy0}, 32'd1);
        resetn0 = 1'b0;
        @(negedge clk_cpu);
        chk("mid_rst_busy", {31'b0, busy0}, 32'd1);
        resetn0 = 1'b1;
        count_busy(cnt, rseen);
        chk("reclear_len", cnt, 32'd2048);
        access(0, 4'h0, 13'h0100, 32'h0, rd, lat);
        chk("reclear_zero", rd, 32'h0);

        // OUT_REG=1 instance.
        access(1, 4'hF, 13'h0100, 32'hCAFEF00D, rd, lat);
        chk("or_wr_lat", lat, 32'd1);
        access(1, 4'h0, 13'h0100, 32'h0, rd, lat);
        chk("or_rd_lat", lat, 32'd2);
        chk("or_rd_data", rd, 32'hCAFEF00D);
        access(1, 4'hF, 13'h0200, 32'h12345678, rd, lat);
        chk("or_wr_keeps", rd, 32'hCAFEF00D);

        resetn1 = 1'b0;
        @(negedge clk_cpu);
        chk("nc_rst_rdata", rdata1, 32'h0);
        resetn1 = 1'b1;
        @(negedge clk_cpu);
        access(1, 4'h0, 13'h0200, 32'h0, rd, lat);
        chk("nc_keep_data", rd, 32'h12345678);
        chk("nc_keep_lat", lat, 32'd2);
        chk("nc_never_busy", {31'b0, busy1_seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
